// File: rtl/gate_tester_pkg.sv
// Shared encodings for the two-input gate exerciser: expected-gate opcodes,
// FSM states and the number of input vectors walked per run.
package gate_tester_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 4;

    // Opcodes 6 and 7 are reserved and never start a run.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_XNOR);
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the supported two-input gates:
// (op, a, b) -> expected output.
module gate_ref_model
    import gate_tester_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       expected
);

    always_comb begin
        expected = 1'b0;
        case (op)
            OP_AND:  expected =   a & b;
            OP_NAND: expected = ~(a & b);
            OP_OR:   expected =   a | b;
            OP_NOR:  expected = ~(a | b);
            OP_XOR:  expected =   a ^ b;
            OP_XNOR: expected = ~(a ^ b);
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tester.sv
// Sequential truth-table exerciser: walks A/B through 00,01,10,11, samples Y
// after SETTLE_CYCLES cycles per vector and compares against the chosen gate.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] captured,
    output logic [3:0] fail_mask
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       IDX_LAST = 2'(NUM_VECTORS - 1);

    state_e           state;
    state_e           state_nxt;
    logic [2:0]       op_latched;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             expected;
    logic             start_ok;
    logic             settle_end;
    logic             last_vec;
    logic             y_miss;

    gate_ref_model u_ref (
        .op       (op_latched),
        .a        (A),
        .b        (B),
        .expected (expected)
    );

    assign start_ok   = start && op_legal(op);
    assign settle_end = (cnt == CNT_LAST);
    assign last_vec   = (idx == IDX_LAST);
    assign y_miss     = (Y != expected);

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_end) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                state_nxt = last_vec ? DONE : SETTLE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_latched <= 3'd0;
            idx        <= 2'd0;
            cnt        <= '0;
            A          <= 1'b0;
            B          <= 1'b0;
            pass       <= 1'b0;
            captured   <= 4'd0;
            fail_mask  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        op_latched <= op;
                        idx        <= 2'd0;
                        cnt        <= '0;
                        A          <= 1'b0;
                        B          <= 1'b0;
                        pass       <= 1'b0;
                        captured   <= 4'd0;
                        fail_mask  <= 4'd0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                end
                SAMPLE: begin
                    captured[idx]  <= Y;
                    fail_mask[idx] <= y_miss;
                    // Bit 3 of fail_mask is still clear here, so the earlier
                    // bits plus this sample give the final verdict.
                    if (last_vec) begin
                        pass <= (fail_mask == 4'd0) && !y_miss;
                    end else begin
                        idx    <= idx + 2'd1;
                        {A, B} <= idx + 2'd1;
                        cnt    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two instances (settle 1 and 3) driven by a truth-table
// gate stand-in, checked against a truth-table model of the expected results.
module tb_gate_tester;
    import gate_tester_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_s [2];
    logic       start_s [2];
    logic [2:0] op_s    [2];
    logic [3:0] ytab_s  [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic [3:0] cap_s   [2];
    logic [3:0] fm_s    [2];
    logic       y0, y1;

    // Gate under test: Y is the truth-table bit selected by {A,B}.
    assign y0 = ytab_s[0][{a_s[0], b_s[0]}];
    assign y1 = ytab_s[1][{a_s[1], b_s[1]}];

    gate_tester #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]), .op(op_s[0]), .Y(y0),
        .A(a_s[0]), .B(b_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .captured(cap_s[0]), .fail_mask(fm_s[0])
    );

    gate_tester #(.SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]), .op(op_s[1]), .Y(y1),
        .A(a_s[1]), .B(b_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .captured(cap_s[1]), .fail_mask(fm_s[1])
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit i = gate output for A=i[1], B=i[0].
    function automatic logic [3:0] truth(input logic [2:0] op);
        case (op)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b0111;
            3'd2:    return 4'b1110;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input int u, input string tag);
        chk({tag, "_ab"},   {6'd0, a_s[u], b_s[u]},    8'd0);
        chk({tag, "_ctl"},  {5'd0, busy_s[u], done_s[u], pass_s[u]}, 8'd0);
        chk({tag, "_cap"},  {4'd0, cap_s[u]},          8'd0);
        chk({tag, "_fail"}, {4'd0, fm_s[u]},           8'd0);
    endtask

    // One complete run; with disturb set, start and op are wiggled mid-run
    // and start is raised again during the done cycle.
    task automatic run(input int u, input int s, input logic [2:0] op,
                       input logic [3:0] yt, input bit disturb);
        logic [3:0] exp_fail;
        int         v;
        exp_fail   = yt ^ truth(op);
        op_s[u]    = op;
        ytab_s[u]  = yt;
        start_s[u] = 1'b1;
        tick();
        start_s[u] = 1'b0;
        for (int j = 0; j < 4 * (s + 1); j++) begin
            v = j / (s + 1);
            chk("vec_ab", {6'd0, a_s[u], b_s[u]}, 8'(v));
            chk("run_busy_done", {6'd0, busy_s[u], done_s[u]}, 8'b10);
            if (disturb && j == 2) begin
                start_s[u] = 1'b1;
                op_s[u]    = op ^ 3'd1;
            end
            if (disturb && j == 3) begin
                start_s[u] = 1'b0;
            end
            tick();
        end
        chk("end_busy_done", {6'd0, busy_s[u], done_s[u]}, 8'b11);
        chk("captured",      {4'd0, cap_s[u]}, {4'd0, yt});
        chk("fail_mask",     {4'd0, fm_s[u]},  {4'd0, exp_fail});
        chk("pass",          {7'd0, pass_s[u]}, {7'd0, (exp_fail == 4'd0)});
        if (disturb) begin
            start_s[u] = 1'b1;
        end
        tick();
        start_s[u] = 1'b0;
        op_s[u]    = op;
        chk("post_busy_done", {6'd0, busy_s[u], done_s[u]}, 8'b00);
        chk("post_ab_hold",   {6'd0, a_s[u], b_s[u]}, 8'd3);
        chk("post_pass_hold", {7'd0, pass_s[u]}, {7'd0, (exp_fail == 4'd0)});
        if (disturb) begin
            tick();
            chk("done_start_ignored", {6'd0, busy_s[u], done_s[u]}, 8'b00);
        end
    endtask

    initial begin
        int         u;
        logic [2:0] rop;
        logic [3:0] ryt;

        for (int i = 0; i < 2; i++) begin
            rst_n_s[i] = 1'b0;
            start_s[i] = 1'b0;
            op_s[i]    = 3'd0;
            ytab_s[i]  = 4'd0;
        end
        repeat (3) tick();
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;
        tick();
        check_idle_zero(0, "reset0");
        check_idle_zero(1, "reset1");

        run(0, 1, 3'd0, 4'b1000, 1'b0);   // AND vs AND gate
        run(0, 1, 3'd1, 4'b1000, 1'b0);   // NAND vs AND gate
        run(0, 1, 3'd1, 4'b0111, 1'b0);   // NAND vs NAND gate
        run(0, 1, 3'd4, 4'b0000, 1'b0);   // XOR vs Y tied low
        run(1, 3, 3'd2, 4'b1110, 1'b0);   // OR, long settle
        run(0, 1, 3'd0, 4'b1000, 1'b1);   // restart and op change ignored

        // Reset while vector 2 is on A/B.
        op_s[0]    = 3'd2;
        ytab_s[0]  = 4'b1110;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (4) tick();
        chk("mid_vec2", {6'd0, a_s[0], b_s[0]}, 8'd2);
        chk("mid_cap",  {4'd0, cap_s[0]}, 8'b0010);
        rst_n_s[0] = 1'b0;
        tick();
        rst_n_s[0] = 1'b1;
        check_idle_zero(0, "mid_reset");
        for (int j = 0; j < 8; j++) begin
            chk("no_done_after_rst", {6'd0, busy_s[0], done_s[0]}, 8'b00);
            tick();
        end

        // Reserved opcodes never start a run.
        for (int k = 6; k < 8; k++) begin
            op_s[0]    = 3'(k);
            start_s[0] = 1'b1;
            tick();
            start_s[0] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                chk("reserved_op", {6'd0, busy_s[0], done_s[0]}, 8'b00);
                tick();
            end
        end

        for (int n = 0; n < 24; n++) begin
            u   = int'($urandom_range(0, 1));
            rop = 3'($urandom_range(0, 5));
            ryt = 4'($urandom);
            run(u, (u == 0) ? 1 : 3, rop, ryt, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
